// File: rtl/mux21_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux21_rr_arbiter
//
// Round-robin arbiter and sequencer for a shared WIDTH-bit 2:1 mux. Two
// valid/ready requesters (A, B) compete for the mux. The arbiter drives the
// mux select. The selected mux output comes back on mux_data and is captured
// in a one-entry output register that has its own valid/ready handshake
// toward the consumer. MAX_BURST limits how many consecutive beats one owner
// may take while the other requester is waiting.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   a_valid    in   requester A has a beat
//   a_ready    out  beat from A accepted this cycle
//   b_valid    in   requester B has a beat
//   b_ready    out  beat from B accepted this cycle
//   mux_sel    out  mux select: 1 = A data, 0 = B data
//   mux_data   in   mux output (WIDTH), returned from the external mux
//   out_valid  out  output register holds a beat
//   out_data   out  output register contents (WIDTH)
//   out_ready  in   consumer accepts the beat
//   owner      out  arbiter state: 00 IDLE, 01 OWN_A, 10 OWN_B
// -----------------------------------------------------------------------------
module mux21_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             mux_sel,
  input  logic [WIDTH-1:0] mux_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       owner
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_A = 2'b01,
    ST_OWN_B = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_sel_q, last_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic can_accept;
  logic grant_a;
  logic grant_b;
  logic restart;
  logic owner_change;

  // Burst counter increment, saturating at MAX_BURST.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_MAX) begin
      return CNT_MAX;
    end
    return c + CNT_ONE;
  endfunction

  // Single-entry output stage: room for a new beat when empty or draining.
  assign can_accept = !out_valid_q || out_ready;

  // Winner selection. Gated by rst_n so the reset cycle never handshakes.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    restart = 1'b0;
    if (rst_n && can_accept) begin
      unique case (state_q)
        ST_OWN_A: begin
          if (a_valid && (cnt_q < CNT_MAX)) begin
            grant_a = 1'b1;
          end else if (b_valid) begin
            grant_b = 1'b1;
          end else if (a_valid) begin
            // Burst limit hit but nobody else is waiting: A keeps the mux
            // and starts a fresh burst.
            grant_a = 1'b1;
            restart = 1'b1;
          end
        end
        ST_OWN_B: begin
          if (b_valid && (cnt_q < CNT_MAX)) begin
            grant_b = 1'b1;
          end else if (a_valid) begin
            grant_a = 1'b1;
          end else if (b_valid) begin
            grant_b = 1'b1;
            restart = 1'b1;
          end
        end
        default: begin
          // IDLE (and the unused encoding): tie goes to whoever was not
          // served last; last_sel_q = 0 after reset, so A goes first.
          if (a_valid && b_valid) begin
            if (last_sel_q) begin
              grant_b = 1'b1;
            end else begin
              grant_a = 1'b1;
            end
          end else if (a_valid) begin
            grant_a = 1'b1;
          end else if (b_valid) begin
            grant_b = 1'b1;
          end
        end
      endcase
    end
  end

  assign owner_change = grant_a ? (state_q != ST_OWN_A) : (state_q != ST_OWN_B);

  // Next-state for arbiter state, burst counter and output register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_sel_d  = last_sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (grant_a || grant_b) begin
      // New beat overwrites the register even if it is being drained now.
      out_data_d  = mux_data;
      out_valid_d = 1'b1;
      last_sel_d  = grant_a;
      state_d     = grant_a ? ST_OWN_A : ST_OWN_B;
      cnt_d       = (owner_change || restart) ? CNT_ONE : sat_inc(cnt_q);
    end else begin
      if (out_ready && out_valid_q) begin
        out_valid_d = 1'b0;
      end
      if (can_accept && !a_valid && !b_valid) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
  end

  // State register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_sel_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_sel_q  <= last_sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  // With no winner the select holds its last value so the mux does not toggle.
  assign mux_sel   = grant_a ? 1'b1 : (grant_b ? 1'b0 : last_sel_q);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign owner     = state_q;

  a_b_exclusive: assert property (@(posedge clk) !(a_ready && b_ready));

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
module tb_mux21_rr_arbiter;

  localparam int W    = 4;
  localparam int MAXB = 4;

  logic         clk;
  logic         rst_n;
  logic         a_valid, b_valid, out_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, mux_sel, out_valid;
  logic [W-1:0] out_data, mux_data;
  logic [1:0]   owner;

  // External 2:1 mux
  assign mux_data = mux_sel ? a_data : b_data;

  mux21_rr_arbiter #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .mux_sel   (mux_sel),
    .mux_data  (mux_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference model: owner 0 none / 1 A / 2 B, run length of current owner.
  int          m_owner;
  int          m_cnt;
  logic        m_last_a;
  logic        m_outv;
  logic [W-1:0] m_outd;
  int          m_win;
  logic        m_restart;
  logic        m_can;
  logic [9:0]  exp_vec;
  wire  [9:0]  got = {a_ready, b_ready, mux_sel, out_valid, owner, out_data};

  function automatic void eval_model();
    logic ea, eb, es;
    int own_v, oth_v;
    m_win     = 0;
    m_restart = 1'b0;
    m_can     = !m_outv || out_ready;
    if (rst_n && m_can) begin
      if (m_owner == 0) begin
        if (a_valid && b_valid) m_win = m_last_a ? 2 : 1;
        else if (a_valid)       m_win = 1;
        else if (b_valid)       m_win = 2;
      end else begin
        own_v = (m_owner == 1) ? int'(a_valid) : int'(b_valid);
        oth_v = (m_owner == 1) ? int'(b_valid) : int'(a_valid);
        if (own_v != 0 && m_cnt < MAXB) m_win = m_owner;
        else if (oth_v != 0)            m_win = 3 - m_owner;
        else if (own_v != 0) begin
          m_win     = m_owner;
          m_restart = 1'b1;
        end
      end
    end
    ea = (m_win == 1);
    eb = (m_win == 2);
    es = ea ? 1'b1 : (eb ? 1'b0 : m_last_a);
    exp_vec = {ea, eb, es, m_outv, 2'(m_owner), m_outd};
  endfunction

  task automatic drive(input logic rn, input logic av, input logic bv,
                       input logic [W-1:0] ad, input logic [W-1:0] bd,
                       input logic ordy);
    rst_n = rn; a_valid = av; b_valid = bv;
    a_data = ad; b_data = bd; out_ready = ordy;
    eval_model();
    @(negedge clk);
  endtask

  task automatic tick();
    if (!rst_n) begin
      m_owner = 0; m_cnt = 0; m_last_a = 1'b0; m_outv = 1'b0; m_outd = '0;
    end else if (m_win != 0) begin
      m_outd   = (m_win == 1) ? a_data : b_data;
      m_outv   = 1'b1;
      m_last_a = (m_win == 1);
      if (m_win != m_owner || m_restart) m_cnt = 1;
      else m_cnt = (m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1;
      m_owner = m_win;
    end else begin
      if (out_ready && m_outv) m_outv = 1'b0;
      if (m_can && !a_valid && !b_valid) begin
        m_owner = 0;
        m_cnt   = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'h5, 4'hA, 1'b1);
      n_cmp++;
      if (got !== exp_vec) begin
        n_bad++;
        $display("FAIL reset_model cyc%0d got=%b exp=%b", i, got, exp_vec);
      end
      n_cmp++;
      if (got !== 10'b0) begin
        n_bad++;
        $display("FAIL reset_values cyc%0d got=%b exp=%b", i, got, 10'b0);
      end
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 4'h5, 4'hA, 1'b1);
    n_cmp++;
    if ({a_ready, b_ready, mux_sel} !== 3'b101) begin
      n_bad++;
      $display("FAIL reset_first_grant got=%b exp=101", {a_ready, b_ready, mux_sel});
    end
    tick();
  endtask

  task automatic test_single();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'(i), 4'hF, 1'b1);
      n_cmp++;
      if (got !== exp_vec) begin
        n_bad++;
        $display("FAIL single_model beat%0d got=%b exp=%b", i, got, exp_vec);
      end
      n_cmp++;
      if ({a_ready, b_ready, mux_sel} !== 3'b101) begin
        n_bad++;
        $display("FAIL single_grant beat%0d got=%b exp=101", i, {a_ready, b_ready, mux_sel});
      end
      if (i > 1) begin
        n_cmp++;
        if (out_data !== 4'(i - 1)) begin
          n_bad++;
          $display("FAIL single_latency beat%0d got=%h exp=%h", i, out_data, 4'(i - 1));
        end
      end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    n_cmp++;
    if ({out_valid, out_data} !== 5'b1_0011) begin
      n_bad++;
      $display("FAIL single_last got=%b exp=10011", {out_valid, out_data});
    end
    tick();
  endtask

  task automatic test_contention();
    logic exp_a, prev_a;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    tick();
    prev_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 1'b1, 4'h1, 4'h8, 1'b1);
      exp_a = ((i / 4) % 2 == 0);
      n_cmp++;
      if (got !== exp_vec) begin
        n_bad++;
        $display("FAIL contention_model cyc%0d got=%b exp=%b", i, got, exp_vec);
      end
      n_cmp++;
      if ({a_ready, b_ready} !== {exp_a, ~exp_a}) begin
        n_bad++;
        $display("FAIL contention_grant cyc%0d got=%b exp=%b", i, {a_ready, b_ready}, {exp_a, ~exp_a});
      end
      if (i > 0) begin
        n_cmp++;
        if (out_data !== (prev_a ? 4'h1 : 4'h8)) begin
          n_bad++;
          $display("FAIL contention_data cyc%0d got=%h exp=%h", i, out_data, prev_a ? 4'h1 : 4'h8);
        end
      end
      prev_a = exp_a;
      tick();
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 4'h3, 4'h6, 1'b0);
      n_cmp++;
      if (got !== exp_vec) begin
        n_bad++;
        $display("FAIL bp_model cyc%0d got=%b exp=%b", i, got, exp_vec);
      end
      n_cmp++;
      if ({a_ready, b_ready, out_valid, out_data} !== 7'b00_1_0001) begin
        n_bad++;
        $display("FAIL bp_hold cyc%0d got=%b exp=0010001", i, {a_ready, b_ready, out_valid, out_data});
      end
      tick();
    end
    // A finished a full burst before the stall, so B is next.
    drive(1'b1, 1'b1, 1'b1, 4'h3, 4'h6, 1'b1);
    n_cmp++;
    if ({a_ready, b_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_release got=%b exp=01", {a_ready, b_ready});
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'h3, 4'h6, 1'b1);
    n_cmp++;
    if ({out_valid, out_data} !== 5'b1_0110) begin
      n_bad++;
      $display("FAIL bp_nobubble got=%b exp=10110", {out_valid, out_data});
    end
    tick();
  endtask

  task automatic test_early_release();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'h2, 4'h9, 1'b1);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 4'h2, 4'h9, 1'b1);
    n_cmp++;
    if ({a_ready, b_ready, mux_sel} !== 3'b010) begin
      n_bad++;
      $display("FAIL early_grant_b got=%b exp=010", {a_ready, b_ready, mux_sel});
    end
    n_cmp++;
    if (got !== exp_vec) begin
      n_bad++;
      $display("FAIL early_model got=%b exp=%b", got, exp_vec);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'h2, 4'h9, 1'b1);
    n_cmp++;
    if ({owner, mux_sel, out_data} !== 7'b10_0_1001) begin
      n_bad++;
      $display("FAIL early_own_b got=%b exp=1001001", {owner, mux_sel, out_data});
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'h2, 4'h9, 1'b1);
    n_cmp++;
    if ({owner, mux_sel, out_valid} !== 4'b00_0_0) begin
      n_bad++;
      $display("FAIL early_idle got=%b exp=0000", {owner, mux_sel, out_valid});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b1, 4'h1, 4'h8, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 4'h1, 4'h8, 1'b0);
    n_cmp++;
    if ({out_valid, out_data, a_ready, b_ready} !== 7'b1_1000_00) begin
      n_bad++;
      $display("FAIL mid_loaded got=%b exp=1100000", {out_valid, out_data, a_ready, b_ready});
    end
    tick();
    drive(1'b0, 1'b1, 1'b1, 4'h1, 4'h8, 1'b1);
    n_cmp++;
    if ({a_ready, b_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_no_handshake got=%b exp=00", {a_ready, b_ready});
    end
    tick();
    drive(1'b1, 1'b1, 1'b1, 4'h1, 4'h8, 1'b1);
    n_cmp++;
    if ({out_valid, out_data, owner, a_ready, mux_sel} !== 9'b0_0000_00_1_1) begin
      n_bad++;
      $display("FAIL mid_after got=%b exp=000000011", {out_valid, out_data, owner, a_ready, mux_sel});
    end
    tick();
  endtask

  task automatic test_random();
    logic rn, av, bv, ordy;
    for (int i = 0; i < 800; i++) begin
      rn   = ($urandom_range(0, 59) != 0);
      av   = ($urandom_range(0, 3) != 0);
      bv   = ($urandom_range(0, 2) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      drive(rn, av, bv, 4'($urandom), 4'($urandom), ordy);
      n_cmp++;
      if (got !== exp_vec) begin
        n_bad++;
        $display("FAIL random cyc%0d got=%b exp=%b", i, got, exp_vec);
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = '0; b_data = '0;
    m_owner = 0; m_cnt = 0; m_last_a = 1'b0; m_outv = 1'b0; m_outd = '0;
    m_win = 0; m_restart = 1'b0; m_can = 1'b1; exp_vec = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_early_release();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
